// File: rtl/weight_sink_loader_if.sv
// Weight stream (valid/ready) and ROM-style read port bundled together.
interface weight_sink_loader_if #(
  parameter int unsigned PREC   = 16,
  parameter int unsigned BLOCK  = 1,
  parameter int unsigned AWIDTH = 6
);
  logic [PREC-1:0]       data_in [BLOCK];
  logic                  data_in_valid;
  logic                  data_in_ready;
  logic [AWIDTH-1:0]     rd_addr;
  logic                  rd_ce;
  logic [PREC*BLOCK-1:0] rd_data;
  logic                  rd_valid;

  modport master (
    output data_in, data_in_valid, rd_addr, rd_ce,
    input  data_in_ready, rd_data, rd_valid
  );

  modport slave (
    input  data_in, data_in_valid, rd_addr, rd_ce,
    output data_in_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/weight_sink_loader.sv
// Runtime weight loader: captures a streamed tensor into RAM, then serves it
// through a 2-cycle address/ce read port laid out like the weight ROMs.
module weight_sink_loader #(
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_0 = 32,
  parameter int unsigned WEIGHT_TENSOR_SIZE_DIM_1 = 1,
  parameter int unsigned WEIGHT_PRECISION_0       = 16,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_0 = 1,
  parameter int unsigned WEIGHT_PARALLELISM_DIM_1 = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reload,
  output logic                 loaded,
  weight_sink_loader_if.slave  bus
);

  localparam int unsigned PREC     = WEIGHT_PRECISION_0;
  localparam int unsigned BLOCK    = WEIGHT_PARALLELISM_DIM_0 * WEIGHT_PARALLELISM_DIM_1;
  localparam int unsigned IN_DEPTH = (WEIGHT_TENSOR_SIZE_DIM_0 * WEIGHT_TENSOR_SIZE_DIM_1) / BLOCK;
  localparam int unsigned AWIDTH   = $clog2(IN_DEPTH) + 1;
  localparam int unsigned IDX_W    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int unsigned WWIDTH   = PREC * BLOCK;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [AWIDTH-1:0]   wr_cnt;
  logic [AWIDTH-1:0]   wr_cnt_nxt;
  logic                ready_q;
  logic                ready_nxt;
  logic                loaded_q;
  logic                loaded_nxt;
  logic                wr_en_c;
  logic                last_beat_c;
  logic [WWIDTH-1:0]   wr_word_c;
  logic                issue_c;

  logic [WWIDTH-1:0]   mem [IN_DEPTH];
  logic [WWIDTH-1:0]   rd_word_q;
  logic                rd_v1_q;
  logic                rd_valid_q;
  logic [WWIDTH-1:0]   rd_data_q;

  // Write strobe and final-beat detect; ready is a registered copy of state==LOAD
  assign wr_en_c     = (state == LOAD) && bus.data_in_valid;
  assign last_beat_c = (wr_cnt == AWIDTH'(IN_DEPTH - 1));

  // Read issue: only a loaded tensor and an in-range address start a read
  assign issue_c = bus.rd_ce && loaded_q && (bus.rd_addr < AWIDTH'(IN_DEPTH));

  // Pack the beat so element j lands in bits [PREC*j +: PREC]
  always_comb begin
    wr_word_c = '0;
    for (int j = 0; j < int'(BLOCK); j++) begin
      wr_word_c[PREC*j +: PREC] = bus.data_in[j];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = LOAD;
      LOAD:    if (wr_en_c && last_beat_c) state_nxt = DONE;
      DONE:    if (reload) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode: write counter and next values of the registered flags
  always_comb begin
    wr_cnt_nxt = wr_cnt;
    ready_nxt  = (state_nxt == LOAD);
    loaded_nxt = (state_nxt == DONE);
    if (wr_en_c) begin
      wr_cnt_nxt = last_beat_c ? '0 : wr_cnt + AWIDTH'(1);
    end else if ((state == DONE) && reload) begin
      wr_cnt_nxt = '0;
    end
  end

  // Registered control outputs and write pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt   <= '0;
      ready_q  <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      wr_cnt   <= wr_cnt_nxt;
      ready_q  <= ready_nxt;
      loaded_q <= loaded_nxt;
    end
  end

  // Weight RAM; the read samples on the issue edge so later LOAD writes cannot disturb it
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_cnt[IDX_W-1:0]] <= wr_word_c;
    end
    if (issue_c) begin
      rd_word_q <= mem[bus.rd_addr[IDX_W-1:0]];
    end
  end

  // Second read stage: valid strobe every cycle, data held between valid reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_v1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_v1_q    <= issue_c;
      rd_valid_q <= rd_v1_q;
      if (rd_v1_q) begin
        rd_data_q <= rd_word_q;
      end
    end
  end

  assign bus.data_in_ready = ready_q;
  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign loaded            = loaded_q;

endmodule

// File: tb/tb_weight_sink_loader.sv
// Randomized bench for weight_sink_loader against a tensor-level model.
module tb_weight_sink_loader;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic reload = 1'b0;
  logic loaded;
  logic reload4 = 1'b0;
  logic loaded4;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  weight_sink_loader_if #(.PREC(16), .BLOCK(1), .AWIDTH(6)) bus ();
  weight_sink_loader_if #(.PREC(16), .BLOCK(4), .AWIDTH(3)) bus4 ();

  weight_sink_loader dut (
    .clk    (clk),
    .rst    (rst),
    .reload (reload),
    .loaded (loaded),
    .bus    (bus)
  );

  weight_sink_loader #(
    .WEIGHT_TENSOR_SIZE_DIM_0 (16),
    .WEIGHT_TENSOR_SIZE_DIM_1 (1),
    .WEIGHT_PRECISION_0       (16),
    .WEIGHT_PARALLELISM_DIM_0 (4),
    .WEIGHT_PARALLELISM_DIM_1 (1)
  ) dut4 (
    .clk    (clk),
    .rst    (rst),
    .reload (reload4),
    .loaded (loaded4),
    .bus    (bus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tensor contents, beats received, loaded flag and a 2-deep read queue
  logic [15:0] mem_m [DEPTH];
  int          beats_m = 0;
  bit          loaded_m = 1'b0;
  bit          ready_m = 1'b0;
  bit          fresh_m = 1'b1;
  bit          p0_v = 1'b0;
  logic [15:0] p0_d = '0;
  bit          rv_exp = 1'b0;
  bit          data_known = 1'b0;
  logic [15:0] data_exp = '0;
  bit          hs_m;
  bit          iss_m;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        beats_m = 0; loaded_m = 0; ready_m = 0; fresh_m = 1;
        p0_v = 0; rv_exp = 0; data_known = 0;
      end else begin
        hs_m  = bus.data_in_valid && ready_m;
        iss_m = bus.rd_ce && loaded_m && (int'(bus.rd_addr) < DEPTH);
        rv_exp = p0_v;
        if (p0_v) begin
          data_exp = p0_d;
          data_known = 1;
        end
        p0_v = iss_m;
        if (iss_m) p0_d = mem_m[bus.rd_addr[4:0]];
        if (fresh_m) begin
          fresh_m = 0;
          ready_m = 1;
        end else if (hs_m) begin
          mem_m[beats_m] = bus.data_in[0];
          beats_m++;
          if (beats_m == DEPTH) begin
            beats_m = 0;
            loaded_m = 1;
            ready_m = 0;
          end
        end else if (reload && loaded_m) begin
          loaded_m = 0;
          ready_m = 1;
        end
      end
    end
  end

  // Compare process: every output checked against the model each cycle
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("ready", 64'(bus.data_in_ready), 64'(ready_m));
        chk("loaded", 64'(loaded), 64'(loaded_m));
        chk("rd_valid", 64'(bus.rd_valid), 64'(rv_exp));
        if (data_known) chk("rd_data", 64'(bus.rd_data), 64'(data_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n beats of base+i; mode 1 toggles valid with random gaps and stray reloads
  task automatic load_tensor(input logic [15:0] base, input int n, input int mode);
    int idx = 0;
    int guard = 0;
    bit v;
    bit rdy;
    while (idx < n && guard < 2000) begin
      v = (mode == 0) ? 1'b1 : (((guard % 2) == 0) && ($urandom_range(0, 3) != 0));
      bus.data_in_valid = v;
      bus.data_in[0] = base + 16'(idx);
      bus.rd_ce = 1'($urandom_range(0, 1));
      bus.rd_addr = 6'($urandom_range(0, 40));
      reload = (mode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      rdy = bus.data_in_ready;
      step();
      if (v && rdy) idx++;
      guard++;
    end
    bus.data_in_valid = 0;
    bus.rd_ce = 0;
    reload = 0;
    if (idx < n) chk("load_timeout", 64'(idx), 64'(n));
  endtask

  // Read every word, plus random gaps and out-of-range probes
  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      bus.rd_ce = 1;
      bus.rd_addr = 6'(a);
      step();
      if ($urandom_range(0, 3) == 0) begin
        bus.rd_ce = 1'($urandom_range(0, 1));
        bus.rd_addr = 6'($urandom_range(32, 63));
        step();
      end
    end
    bus.rd_ce = 0;
    step();
    step();
  endtask

  initial begin
    bus.data_in_valid = 0; bus.data_in[0] = '0; bus.rd_ce = 0; bus.rd_addr = '0;
    bus4.data_in_valid = 0; bus4.rd_ce = 0; bus4.rd_addr = '0;
    for (int j = 0; j < 4; j++) bus4.data_in[j] = '0;

    // Reset state
    step();
    chk_en = 1;
    step();
    chk("rst_ready", 64'(bus.data_in_ready), 64'h0);
    chk("rst_loaded", 64'(loaded), 64'h0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'h0);
    rst = 1;
    chk("ready_before_arm", 64'(bus.data_in_ready), 64'h0);
    step();
    chk("ready_after_arm", 64'(bus.data_in_ready), 64'h1);

    // Read before loaded must not issue
    bus.rd_ce = 1; bus.rd_addr = 6'd5;
    step(); bus.rd_ce = 0; step();
    chk("early_read_valid", 64'(bus.rd_valid), 64'h0);

    // Continuous load 0..31, then valid held in DONE is ignored
    load_tensor(16'h0000, DEPTH, 0);
    chk("loaded_after_32", 64'(loaded), 64'h1);
    chk("ready_after_32", 64'(bus.data_in_ready), 64'h0);
    bus.data_in_valid = 1; bus.data_in[0] = 16'hdead;
    repeat (3) step();
    bus.data_in_valid = 0;
    read_all();

    // Literal read of word 3 and out-of-range 32
    bus.rd_ce = 1; bus.rd_addr = 6'd3; step();
    bus.rd_addr = 6'd32; step();
    bus.rd_ce = 0;
    chk("lit_rd3_valid", 64'(bus.rd_valid), 64'h1);
    chk("lit_rd3_data", 64'(bus.rd_data), 64'h0003);
    step();
    chk("lit_rd32_valid", 64'(bus.rd_valid), 64'h0);

    // Reload with a read in flight: old data comes back
    bus.rd_ce = 1; bus.rd_addr = 6'd3; reload = 1;
    step();
    bus.rd_ce = 0; reload = 0;
    chk("reload_loaded_drop", 64'(loaded), 64'h0);
    step();
    chk("inflight_valid", 64'(bus.rd_valid), 64'h1);
    chk("inflight_data", 64'(bus.rd_data), 64'h0003);
    load_tensor(16'h1000, DEPTH, 1);
    step();
    read_all();

    // Reset after 10 beats, then a full fresh tensor
    reload = 1; step(); reload = 0;
    load_tensor(16'h2000, 10, 0);
    rst = 0;
    #1;
    chk("midrst_ready", 64'(bus.data_in_ready), 64'h0);
    chk("midrst_loaded", 64'(loaded), 64'h0);
    step(); step();
    rst = 1;
    step();
    load_tensor(16'h3000, DEPTH - 1, 1);
    chk("not_loaded_at_31", 64'(loaded), 64'h0);
    load_tensor(16'h3000 + 16'(DEPTH - 1), 1, 0);
    chk("loaded_after_fresh", 64'(loaded), 64'h1);
    read_all();

    // BLOCK=4 instance: 4 beats of {4k+3,4k+2,4k+1,4k}
    begin
      int k = 0;
      int guard = 0;
      while (k < 4 && guard < 100) begin
        for (int j = 0; j < 4; j++) bus4.data_in[j] = 16'(4 * k + j);
        bus4.data_in_valid = 1;
        if (bus4.data_in_ready) begin
          step();
          k++;
          if (k == 3) chk("b4_not_loaded_3", 64'(loaded4), 64'h0);
        end else begin
          step();
        end
        guard++;
      end
      bus4.data_in_valid = 0;
      if (k < 4) chk("b4_load_timeout", 64'(k), 64'd4);
    end
    chk("b4_loaded", 64'(loaded4), 64'h1);
    bus4.rd_ce = 1; bus4.rd_addr = 3'd0; step();
    bus4.rd_addr = 3'd3; step();
    bus4.rd_addr = 3'd4;
    chk("b4_rd0_valid", 64'(bus4.rd_valid), 64'h1);
    chk("b4_rd0_data", 64'(bus4.rd_data), 64'h0003_0002_0001_0000);
    step();
    bus4.rd_ce = 0;
    chk("b4_rd3_valid", 64'(bus4.rd_valid), 64'h1);
    chk("b4_rd3_data", 64'(bus4.rd_data), 64'h000f_000e_000d_000c);
    step();
    chk("b4_rd4_valid", 64'(bus4.rd_valid), 64'h0);
    chk("b4_rd4_hold", 64'(bus4.rd_data), 64'h000f_000e_000d_000c);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/weight_sink_loader.md
Name: weight_sink_loader

Overview:
Receive-side counterpart of the per-layer weight source. It accepts a weight tensor streamed over a valid/ready interface, one parallel block per beat, and writes the beats into an internal RAM. It then serves the stored blocks through an address/ce read port with 2-cycle latency, matching the layout and timing of the generated weight ROMs. This lets weights be loaded at runtime instead of through readmemh.

Parameters:
WEIGHT_TENSOR_SIZE_DIM_0, 32, tensor columns
WEIGHT_TENSOR_SIZE_DIM_1, 1, tensor rows
WEIGHT_PRECISION_0, 16, bits per element
WEIGHT_PARALLELISM_DIM_0, 1, elements per beat along dim 0
WEIGHT_PARALLELISM_DIM_1, 1, elements per beat along dim 1
BLOCK, PAR_DIM_0*PAR_DIM_1 (derived), elements per beat
IN_DEPTH, (DIM_0*DIM_1)/BLOCK (derived), beats per tensor and RAM words
AWIDTH, $clog2(IN_DEPTH)+1 (derived), address/counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
data_in  in  [PREC-1:0] x BLOCK (unpacked)  weight beat
data_in_valid  in  1  beat valid
data_in_ready  out  1  sink can accept a beat
reload  in  1  1-cycle pulse that re-arms loading
loaded  out  1  full tensor stored
rd_addr  in  AWIDTH  read word address
rd_ce  in  1  read enable
rd_data  out  PREC*BLOCK  packed word; element j at bits [PREC*j +: PREC]
rd_valid  out  1  rd_data valid

Behaviour:
- Reset (rst=0, async): state=IDLE, wr_cnt=0, loaded=0, data_in_ready=0, rd_valid=0 and its pipeline cleared. RAM contents are not cleared.
- States:
  - IDLE: move to LOAD on the next clk unconditionally.
  - LOAD: data_in_ready=1. A handshake (valid&ready) writes the packed data_in into RAM[wr_cnt] and increments wr_cnt. The handshake at wr_cnt==IN_DEPTH-1 sets wr_cnt=0, moves to DONE, and sets loaded=1 in the next cycle.
  - DONE: data_in_ready=0 and data_in_valid is ignored. reload=1 moves to LOAD, clears loaded, and sets wr_cnt=0.
- reload outside DONE is ignored. The stream does not restart mid-load.
- data_in_ready is decoded from registered state only (no combinational path from valid). A stalled valid holds wr_cnt unchanged.
- Packing: data_in[j] maps to word bits [PREC*j +: PREC], j=0..BLOCK-1. This is the inverse of the source unpacking.
- Read port, 2-stage pipeline:
  - Cycle t: issue = rd_ce & loaded & (rd_addr<IN_DEPTH).
  - Cycle t+2: rd_valid=1 and rd_data=RAM[rd_addr].
  - Non-issued reads produce rd_valid=0 at t+2, and rd_data holds its last value.
  - Back-to-back reads are fully pipelined, one per cycle.
- Reload with reads in flight: reads issued while loaded=1 complete with valid data from the old contents. No write can land before they finish (the earliest LOAD write is the cycle after reload).
- Out-of-range rd_addr (>=IN_DEPTH) never asserts rd_valid.
- Reset mid-load: partial contents are kept but loaded=0. Loading restarts at word 0.

Test Plan:
- Reset then continuous valid with defaults (IN_DEPTH=32): data_in_ready rises 1 cycle after reset release. 32 beats with values 0x0000..0x001F are accepted. loaded=1 the cycle after beat 31, and data_in_ready=0 from then on.
- Valid toggled 1/0 every cycle plus random ready-side stalls: exactly 32 handshakes are stored, in order. Reading addr 0..31 back-to-back returns 0x0000..0x001F with rd_valid 2 cycles after each rd_ce.
- BLOCK=4 (PAR0=4, DIM_0=16): beat {3,2,1,0} stored. Read addr 0 gives rd_data=0x0003_0002_0001_0000 and IN_DEPTH=4.
- Read before loaded: rd_ce=1 at addr 5 gives rd_valid=0. Read at rd_addr=32 after load also gives rd_valid=0.
- Issue rd_ce at addr 3 and pulse reload in the same cycle: rd_valid=1 with the old value 0x0003 two cycles later. loaded drops next cycle, and a new tensor of 0x1000+i loads and reads back correctly.
- Assert rst low after 10 beats: ready and loaded drop immediately. After release, 32 fresh beats are required before loaded=1.
